sr_latch_bank_ctrl: RTL and testbench

- Clocked controller that sequences writes into a bank of N gated SR latches (inputs S, R, enable; outputs Q, Q_n).
- Two requesters share the bank through round-robin arbitration.
- Each accepted request becomes a glitch-safe set/clear sequence: S/R setup, enable pulse, hold, then a Q read-back check.
- Sits between software/bus-facing logic and the latch array; it never drives S=R=1 on any latch.

---
 rtl/sr_latch_bank_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_sr_latch_bank_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_bank_ctrl.sv
// sr_latch_bank_ctrl
// Sequences single-latch writes into a bank of N gated SR latches on behalf
// of two requesters that share the bank round-robin. Each accepted write is
// played out as S/R setup, an enable pulse, a hold cycle with enable low,
// and a read-back of Q. Index values >= N are accepted but only produce an
// error completion. All latch drives and completion outputs are registered
// so the latch bank never sees decode glitches, and S and R are never both
// high on any latch.
module sr_latch_bank_ctrl #(
  parameter int N         = 8,
  parameter int IDX_W     = 3,
  parameter int PULSE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [IDX_W-1:0] req0_idx,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [IDX_W-1:0] req1_idx,
  output logic [N-1:0]     lat_s,
  output logic [N-1:0]     lat_r,
  output logic [N-1:0]     lat_en,
  input  logic [N-1:0]     lat_q,
  output logic             busy,
  output logic             done,
  output logic             done_src,
  output logic             err,
  output logic [2:0]       dbg_state
);

  // Sequencer states. IDLE is encoded as zero so dbg_state != 0 mirrors busy.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic             rr_last_q;
  logic             rr_last_d;
  logic             op_q;
  logic             op_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             src_q;
  logic             src_d;

  logic             grant0;
  logic             grant1;
  logic             hs;
  logic [N-1:0]     sel_d;
  logic             in_range_d;
  logic             q_bit_d;

  logic [N-1:0]     lat_s_d;
  logic [N-1:0]     lat_r_d;
  logic [N-1:0]     lat_en_d;
  logic             done_d;
  logic             done_src_d;
  logic             err_d;

  // One-hot decode of a latch index; indices >= N decode to all zeros, which
  // is what keeps out-of-range requests from touching the bank.
  function automatic logic [N-1:0] decode_idx(input logic [IDX_W-1:0] i);
    logic [N-1:0] res;
    res = '0;
    for (int k = 0; k < N; k++) begin
      res[k] = (i == IDX_W'(k));
    end
    return res;
  endfunction

  // Handshake: a requester's write is taken on a rising edge where its valid
  // and ready are both high. ready is combinational, only ever high in IDLE,
  // and only for the single granted requester; a requester keeps valid and
  // its op/idx stable until it sees ready. With both valid, the requester that
  // did not win last time is granted (rr_last resets to 1 so requester 0 wins
  // the first tie).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_last_q;
        grant1 = !rr_last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign hs         = grant0 | grant1;

  // Capture the winning request; the captured fields hold for the whole op.
  always_comb begin
    op_d      = op_q;
    idx_d     = idx_q;
    src_d     = src_q;
    rr_last_d = rr_last_q;
    if (grant0) begin
      op_d      = req0_op;
      idx_d     = req0_idx;
      src_d     = 1'b0;
      rr_last_d = 1'b0;
    end else if (grant1) begin
      op_d      = req1_op;
      idx_d     = req1_idx;
      src_d     = 1'b1;
      rr_last_d = 1'b1;
    end
  end

  assign sel_d      = decode_idx(idx_d);
  assign in_range_d = |sel_d;
  assign q_bit_d    = |(lat_q & sel_d);

  // Next-state logic: SETUP and HOLD are one cycle each, PULSE lasts
  // PULSE_CYC cycles via a down-counter, out-of-range goes straight to CHECK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d = in_range_d ? S_SETUP : S_CHECK;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        cnt_d   = 4'(PULSE_CYC - 1);
      end
      S_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Drive values for the cycle we are about to enter. S/R are presented from
  // SETUP through HOLD, so enable rises only after a full setup cycle and
  // falls a full cycle before S/R are released. The read-back is taken on
  // the edge into CHECK, after the latch has settled through the hold cycle.
  always_comb begin
    lat_s_d    = '0;
    lat_r_d    = '0;
    lat_en_d   = '0;
    done_d     = 1'b0;
    done_src_d = 1'b0;
    err_d      = 1'b0;
    case (state_d)
      S_SETUP, S_HOLD: begin
        lat_s_d = sel_d & {N{op_d}};
        lat_r_d = sel_d & {N{~op_d}};
      end
      S_PULSE: begin
        lat_s_d  = sel_d & {N{op_d}};
        lat_r_d  = sel_d & {N{~op_d}};
        lat_en_d = sel_d;
      end
      S_CHECK: begin
        done_d     = 1'b1;
        done_src_d = src_d;
        err_d      = !in_range_d || (q_bit_d != op_d);
      end
      default: begin
      end
    endcase
  end

  // State, captured request and registered outputs; reset aborts any op and
  // releases every latch drive on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rr_last_q <= 1'b1;
      op_q      <= 1'b0;
      idx_q     <= '0;
      src_q     <= 1'b0;
      lat_s     <= '0;
      lat_r     <= '0;
      lat_en    <= '0;
      done      <= 1'b0;
      done_src  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      src_q     <= src_d;
      lat_s     <= lat_s_d;
      lat_r     <= lat_r_d;
      lat_en    <= lat_en_d;
      done      <= done_d;
      done_src  <= done_src_d;
      err       <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Bench for sr_latch_bank_ctrl: an 8-latch instance driven by directed and
// random requests against a transaction-level model, plus a 6-latch
// instance used for out-of-range index requests.
module tb_sr_latch_bank_ctrl;
  localparam int N = 8;
  localparam int P = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // ---------------- main instance ----------------
  logic         req0_valid = 1'b0, req0_op = 1'b0;
  logic [2:0]   req0_idx = 3'd0;
  logic         req1_valid = 1'b0, req1_op = 1'b0;
  logic [2:0]   req1_idx = 3'd0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] lat_s, lat_r, lat_en, lat_q;
  logic         busy, done, done_src, err;
  logic [2:0]   dbg_state;

  sr_latch_bank_ctrl #(.N(N), .IDX_W(3), .PULSE_CYC(P)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_idx(req0_idx),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_idx(req1_idx),
    .lat_s(lat_s), .lat_r(lat_r), .lat_en(lat_en), .lat_q(lat_q),
    .busy(busy), .done(done), .done_src(done_src), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- 6-latch instance ----------------
  logic       b_valid = 1'b0, b_op = 1'b0;
  logic [2:0] b_idx = 3'd0;
  logic       b1_valid = 1'b0, b1_op = 1'b0;
  logic [2:0] b1_idx = 3'd0;
  logic       b_ready0, b_ready1;
  logic [5:0] b_s, b_r, b_en;
  logic [5:0] b_q = 6'd0;
  logic       b_busy, b_done, b_src, b_err;
  logic [2:0] b_dbg;

  sr_latch_bank_ctrl #(.N(6), .IDX_W(3), .PULSE_CYC(P)) u_oor (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_valid), .req0_ready(b_ready0), .req0_op(b_op), .req0_idx(b_idx),
    .req1_valid(b1_valid), .req1_ready(b_ready1), .req1_op(b1_op), .req1_idx(b1_idx),
    .lat_s(b_s), .lat_r(b_r), .lat_en(b_en), .lat_q(b_q),
    .busy(b_busy), .done(b_done), .done_src(b_src), .err(b_err), .dbg_state(b_dbg)
  );

  // ---------------- latch bank environment ----------------
  // Ideal gated SR latches; fmask/fval force selected Q bits to a stuck value.
  logic [N-1:0] latch_mem = '0;
  logic [N-1:0] fmask = '0;
  logic [N-1:0] fval = '0;
  assign lat_q = (latch_mem & ~fmask) | (fval & fmask);

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (lat_en[i]) begin
        if (lat_s[i]) latch_mem[i] <= 1'b1;
        else if (lat_r[i]) latch_mem[i] <= 1'b0;
      end
    end
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int hs_q[$];
  int grant_q[$];
  int done_cyc = 0;
  logic last_src = 1'b0, last_err = 1'b0;
  int cnt_s5 = 0, cnt_en5 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // An op is described by its offset k in cycles after the handshake cycle:
  // S/R for k=1..P+2, enable for k=2..P+1, done at k=P+3.
  bit           m_active = 1'b0;
  int           m_k = 0;
  logic         m_op = 1'b0;
  logic [2:0]   m_idx = 3'd0;
  logic         m_src = 1'b0;
  logic         m_rr_last = 1'b1;
  logic [N-1:0] m_mem = '0;
  logic [1:0]   exp_q[$];   // {src, err} expected at each completion
  logic         mg0, mg1;

  assign mg0 = !m_active && req0_valid && (!req1_valid || m_rr_last);
  assign mg1 = !m_active && req1_valid && (!req0_valid || !m_rr_last);

  function automatic logic eff_q(input logic [2:0] i);
    return fmask[i] ? fval[i] : m_mem[i];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_active && m_k >= 2 && m_k <= P + 1) m_mem[m_idx] <= m_op;
    if (!rst_n) begin
      m_active  <= 1'b0;
      m_k       <= 0;
      m_rr_last <= 1'b1;
      exp_q.delete();
    end else if (!m_active) begin
      if (mg0 || mg1) begin
        m_active  <= 1'b1;
        m_k       <= 1;
        m_src     <= mg1;
        m_op      <= mg1 ? req1_op : req0_op;
        m_idx     <= mg1 ? req1_idx : req0_idx;
        m_rr_last <= mg1;
        exp_q.push_back({mg1, (fmask[mg1 ? req1_idx : req0_idx] &&
                               fval[mg1 ? req1_idx : req0_idx] != (mg1 ? req1_op : req0_op))});
      end
    end else if (m_k == P + 3) begin
      m_active <= 1'b0;
      m_k      <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [N-1:0] e_s, e_r, e_en, e_mem;
    logic e_done, e_src, e_err;
    logic [1:0] rec;
    #2;
    if (chk_en) begin
      e_s = '0; e_r = '0; e_en = '0;
      e_done = 1'b0; e_src = 1'b0; e_err = 1'b0;
      if (m_active) begin
        if (m_k <= P + 2) begin
          e_s[m_idx] = m_op;
          e_r[m_idx] = !m_op;
        end
        if (m_k >= 2 && m_k <= P + 1) e_en[m_idx] = 1'b1;
        if (m_k == P + 3) begin
          e_done = 1'b1;
          e_src  = m_src;
          e_err  = (eff_q(m_idx) != m_op);
        end
      end
      chk("req0_ready", req0_ready, mg0);
      chk("req1_ready", req1_ready, mg1);
      chk("ready_excl", req0_ready & req1_ready, 0);
      chk("lat_s", lat_s, e_s);
      chk("lat_r", lat_r, e_r);
      chk("lat_en", lat_en, e_en);
      chk("sr_overlap", lat_s & lat_r, 0);
      chk("busy", busy, m_active);
      chk("dbg_busy", dbg_state != 3'd0, m_active);
      chk("done", done, e_done);
      chk("done_src", done_src, e_src);
      chk("err", err, e_err);
      chk("oor_inst_lat", {b_s, b_r, b_en}, 0);
      if (!m_active) begin
        for (int i = 0; i < N; i++) e_mem[i] = eff_q(3'(i));
        chk("latch_q", lat_q, e_mem);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          rec = exp_q.pop_front();
          chk("sb_done", {done_src, err}, rec);
        end
        done_cyc = cyc;
        last_src = done_src;
        last_err = err;
      end
      if (req0_valid && req0_ready) begin hs_q.push_back(cyc); grant_q.push_back(0); end
      if (req1_valid && req1_ready) begin hs_q.push_back(cyc); grant_q.push_back(1); end
      cnt_s5  = cnt_s5 + int'(lat_s[5]);
      cnt_en5 = cnt_en5 + int'(lat_en[5]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input bit r, input logic op, input logic [2:0] idx);
    logic got = 1'b0;
    @(negedge clk);
    if (r) begin req1_valid = 1'b1; req1_op = op; req1_idx = idx; end
    else   begin req0_valid = 1'b1; req0_op = op; req0_idx = idx; end
    for (int n = 0; n < 100 && !got; n++) begin
      #4;
      got = r ? req1_ready : req0_ready;
      @(negedge clk);
    end
    if (r) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
    chk("req_accepted", got, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && m_active; n++) @(negedge clk);
    chk("idle_reached", m_active, 0);
  endtask

  // Both requesters valid continuously; each gets a fresh write after a grant.
  task automatic arb_run(input int ngr);
    int   got_n = 0;
    logic g0, g1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 1'($urandom_range(0, 1)); req0_idx = 3'($urandom_range(0, 3));
    req1_valid = 1'b1; req1_op = 1'($urandom_range(0, 1)); req1_idx = 3'($urandom_range(4, 7));
    for (int n = 0; n < 200 && got_n < ngr; n++) begin
      #4;
      g0 = req0_ready;
      g1 = req1_ready;
      @(negedge clk);
      if (g0) begin got_n++; req0_op = 1'($urandom_range(0, 1)); req0_idx = 3'($urandom_range(0, 3)); end
      if (g1) begin got_n++; req1_op = 1'($urandom_range(0, 1)); req1_idx = 3'($urandom_range(4, 7)); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("arb_grants", got_n, ngr);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic got;
    bit   found;

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_lat_en", lat_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // single set idx 5, requested in the first cycle after release
    @(negedge clk);
    cnt_s5 = 0; cnt_en5 = 0;
    hs_q.delete(); grant_q.delete();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b1; req0_idx = 3'd5;
    #4 got = req0_ready;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("t1_ready_after_rst", got, 1);
    wait_idle();
    chk("t1_hs_count", hs_q.size(), 1);
    if (hs_q.size() == 1) chk("t1_latency", done_cyc - hs_q[0], 5);
    chk("t1_s5_cycles", cnt_s5, 4);
    chk("t1_en5_cycles", cnt_en5, 2);
    chk("t1_src", last_src, 0);
    chk("t1_err", last_err, 0);
    chk("t1_q5", lat_q[5], 1);

    // clear after set on idx 2
    do_req(1'b0, 1'b1, 3'd2);
    wait_idle();
    chk("t2_q2_set", lat_q[2], 1);
    do_req(1'b1, 1'b0, 3'd2);
    wait_idle();
    chk("t2_q2_clear", lat_q[2], 0);
    chk("t2_src", last_src, 1);
    chk("t2_err", last_err, 0);

    // arbitration: order 0,1,0,1 spaced P+4 cycles
    hs_q.delete(); grant_q.delete();
    arb_run(4);
    wait_idle();
    chk("t3_grants", grant_q.size(), 4);
    if (grant_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_order", grant_q[i], i % 2);
      for (int i = 0; i < 3; i++) chk("t3_spacing", hs_q[i+1] - hs_q[i], 6);
    end

    // faulty latch: Q[3] stuck at 0
    fmask = 8'h08; fval = 8'h00;
    do_req(1'b0, 1'b1, 3'd3);
    wait_idle();
    chk("t4_err", last_err, 1);
    do_req(1'b1, 1'b1, 3'd1);
    wait_idle();
    chk("t4_next_err", last_err, 0);
    chk("t4_next_src", last_src, 1);
    fmask = '0;

    // reset mid-pulse on idx 4
    do_req(1'b0, 1'b1, 3'd4);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (lat_en[4]) found = 1'b1;
      else @(negedge clk);
    end
    chk("t5_pulse_seen", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    chk("t5_busy", busy, 0);
    chk("t5_lat_s", lat_s, 0);
    chk("t5_lat_r", lat_r, 0);
    chk("t5_lat_en", lat_en, 0);
    chk("t5_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    grant_q.delete(); hs_q.delete();
    arb_run(1);
    wait_idle();
    chk("t5_grants", grant_q.size(), 1);
    if (grant_q.size() >= 1) chk("t5_first_grant", grant_q[0], 0);

    // random traffic from both requesters
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 6)) @(negedge clk);
          do_req(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
      end
      begin
        for (int j = 0; j < 25; j++) begin
          repeat ($urandom_range(0, 6)) @(negedge clk);
          do_req(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
      end
    join
    wait_idle();

    // out-of-range on the 6-latch instance: idx 6 and 7
    for (int t = 6; t < 8; t++) begin
      @(negedge clk);
      b_valid = 1'b1; b_idx = 3'(t); b_op = 1'(t % 2);
      #2;
      chk("oor_ready", b_ready0, 1);
      chk("oor_done_pre", b_done, 0);
      @(negedge clk);
      b_valid = 1'b0;
      #2;
      chk("oor_done", b_done, 1);
      chk("oor_err", b_err, 1);
      chk("oor_src", b_src, 0);
      chk("oor_busy", b_busy, 1);
      @(negedge clk);
      #2;
      chk("oor_done_clr", b_done, 0);
      chk("oor_idle", b_busy, 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
